epass_arbiter: RTL
==================

// Module: epass_arbiter
// PURPOSE
//  Shares one E-pass validator among N_LANE toll-lane gate controllers. Arbitrates
//  lane requests round-robin, issues one validation job at a time, waits for the
//  result with a timeout, and returns a 2-bit verdict to the granted lane.
//  Verdict encoding matches the lane controller's valid_Epass input:
//  2'b10 = pass (barrier up), 2'b01 = reject. 2'b00 and 2'b11 mean no decision.
// PARAMETERS
//  N_LANE   4    number of requesting lanes (2..8)
//  ID_W     16   width of the E-pass card ID
//  TIMEOUT  200  WAIT cycles allowed before forced reject (1..2**TO_W-1)
//  TO_W     8    timeout counter width
// PORTS
//  clk         in   1             system clock, rising edge
//  reset_n     in   1             asynchronous active-low reset
//  lane_req    in   N_LANE        per-lane validation request (level)
//  lane_id     in   N_LANE*ID_W   per-lane card ID; lane i = bits [i*ID_W +: ID_W]
//  lane_gnt    out  N_LANE        one-hot grant, 1-cycle pulse
//  rsp_valid   out  N_LANE        one-hot verdict strobe, 1-cycle pulse
//  rsp_result  out  2             verdict, meaningful only while rsp_valid != 0
//  rsp_tmo     out  1             verdict was forced by timeout (with rsp_valid)
//  val_start   out  1             validator job start, 1-cycle pulse
//  val_id      out  ID_W          card ID for the job, held from ISSUE to IDLE
//  val_done    in   1             validator result strobe
//  val_result  in   2             validator verdict, sampled with val_done
//  busy        out  1             1 whenever state != IDLE
//  tmo_cnt     out  8             saturating count of timeouts since reset
// BEHAVIOUR
//  - Clock and reset: one clock. reset_n asserts asynchronously and forces state IDLE.
//    All outputs reset to 0. Round-robin pointer resets to N_LANE-1, so lane 0 has top
//    priority first. Reset mid-job aborts the job silently. No rsp_valid is issued.
//  - All outputs are registered.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE:
//    - If any lane_req bit is set, pick the first set lane searching ptr+1, ptr+2, ...
//      modulo N_LANE. Latch its index and lane_id, then go to ISSUE.
//    - If lane_req == 0, stay in IDLE.
//  - ISSUE (1 cycle):
//    - lane_gnt[idx] = 1, val_start = 1, val_id = latched ID. Clear the timeout counter.
//    - val_done is ignored in this cycle. Go to WAIT.
//  - WAIT:
//    - val_done with val_result 2'b10 or 2'b01: latch the verdict, rsp_tmo = 0, go to RESP.
//    - val_done with 2'b00 or 2'b11: ignored, stay in WAIT.
//    - No valid done: increment the counter. When it reaches TIMEOUT, latch verdict
//      2'b01, set rsp_tmo = 1, increment tmo_cnt (saturates at 255), go to RESP.
//    - A valid done in the same cycle as the timeout wins; no timeout is recorded.
//  - RESP (1 cycle):
//    - rsp_valid[idx] = 1 with rsp_result and rsp_tmo. Set ptr = idx, go to IDLE.
//  - Latency: req first seen in IDLE at cycle T gives gnt/val_start at T+1.
//    Earliest done is at T+2, giving rsp_valid at T+3.
//    Lane throughput is bounded by TIMEOUT+3 cycles per job.
//  - Lane protocol: a lane holds req and lane_id stable until rsp_valid for it, then
//    drops req on the next edge. If a lane drops req after its grant, the job still
//    completes and rsp_valid is still issued.
//  - New requests arriving while busy are only arbitrated on return to IDLE.
//    Round-robin guarantees each requesting lane is served within N_LANE jobs.
//  - At most one bit of lane_gnt or rsp_valid is ever set. rsp_result and rsp_tmo are
//    0 when rsp_valid == 0.
// TESTING
//  1. Reset release; lane_req=4'b0001, id=16'h1234; done+2'b10 two cycles after
//     val_start -> val_id=16'h1234 with val_start at T+1; rsp_valid=4'b0001 and
//     rsp_result=2'b10 one cycle after done.
//  2. lane_req=4'b1111 held, each job done with 2'b01 -> grants in order
//     lane0,1,2,3,0; every rsp_result=2'b01.
//  3. Granted lane2, no val_done -> exactly TIMEOUT WAIT cycles, then
//     rsp_valid=4'b0100, rsp_result=2'b01, rsp_tmo=1; tmo_cnt increments 0->1.
//  4. In WAIT, done+2'b00 then done+2'b11 then done+2'b10 -> first two ignored;
//     a single rsp_valid with rsp_result=2'b10.
//  5. Valid done in the exact cycle the counter hits TIMEOUT -> rsp_tmo=0, tmo_cnt
//     unchanged; also check that req dropped after grant still yields rsp_valid.
//  6. Assert reset_n low in WAIT -> all outputs 0 immediately, busy=0, no rsp_valid.
//     After release, lane_req=4'b0011 -> lane0 granted first.

Source files
------------

// File: rtl/epass_arbiter.sv
// Round-robin share of one E-pass validator among N_LANE toll lanes, with a WAIT timeout.
// Registered outputs: req->gnt 1 cycle, done->rsp 1 cycle; lanes hold lane_req while busy.
module epass_arbiter #(
  parameter int N_LANE  = 4,
  parameter int ID_W    = 16,
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_LANE-1:0]      lane_req,
  input  logic [N_LANE*ID_W-1:0] lane_id,
  output logic [N_LANE-1:0]      lane_gnt,
  output logic [N_LANE-1:0]      rsp_valid,
  output logic [1:0]             rsp_result,
  output logic                   rsp_tmo,
  output logic                   val_start,
  output logic [ID_W-1:0]        val_id,
  input  logic                   val_done,
  input  logic [1:0]             val_result,
  output logic                   busy,
  output logic [7:0]             tmo_cnt
);
  localparam int IDX_W = (N_LANE > 1) ? $clog2(N_LANE) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [IDX_W-1:0]  pick;
  logic              found;
  logic [ID_W-1:0]   pick_id;
  logic [N_LANE-1:0] one_pick, one_idx;
  logic [TO_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic              done_ok, tmo_hit;

  logic [N_LANE-1:0] gnt_nxt, rv_nxt;
  logic [1:0]        res_nxt;
  logic              tmo_nxt, vs_nxt, busy_nxt;
  logic [ID_W-1:0]   vid_nxt;
  logic [7:0]        tcnt_nxt;

  // First requesting lane after ptr, wrapping; ptr itself is searched last.
  always_comb begin : arb
    int c;
    c       = 0;
    found   = 1'b0;
    pick    = '0;
    pick_id = '0;
    for (int k = 1; k <= N_LANE; k++) begin
      c = (int'(ptr) + k) % N_LANE;
      for (int i = 0; i < N_LANE; i++) begin
        if (!found && (c == i) && lane_req[i]) begin
          found = 1'b1;
          pick  = IDX_W'(i);
        end
      end
    end
    for (int i = 0; i < N_LANE; i++) begin
      if (pick == IDX_W'(i)) pick_id = lane_id[i*ID_W +: ID_W];
    end
  end

  assign one_pick = N_LANE'(1) << pick;
  assign one_idx  = N_LANE'(1) << idx;
  assign cnt_inc  = cnt + TO_W'(1);
  assign tmo_hit  = (cnt_inc == TO_W'(TIMEOUT));
  // Only 2'b10 / 2'b01 are decisions; 2'b00 / 2'b11 strobes are noise.
  assign done_ok  = val_done && (val_result[1] ^ val_result[0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= IDX_W'(N_LANE - 1);
      idx        <= '0;
      cnt        <= '0;
      lane_gnt   <= '0;
      rsp_valid  <= '0;
      rsp_result <= 2'b00;
      rsp_tmo    <= 1'b0;
      val_start  <= 1'b0;
      val_id     <= '0;
      busy       <= 1'b0;
      tmo_cnt    <= 8'd0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      lane_gnt   <= gnt_nxt;
      rsp_valid  <= rv_nxt;
      rsp_result <= res_nxt;
      rsp_tmo    <= tmo_nxt;
      val_start  <= vs_nxt;
      val_id     <= vid_nxt;
      busy       <= busy_nxt;
      tmo_cnt    <= tcnt_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done_ok || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; pulses default to zero every cycle.
  always_comb begin : out_nxt
    gnt_nxt  = '0;
    rv_nxt   = '0;
    res_nxt  = 2'b00;
    tmo_nxt  = 1'b0;
    vs_nxt   = 1'b0;
    vid_nxt  = val_id;
    idx_nxt  = idx;
    ptr_nxt  = ptr;
    cnt_nxt  = cnt;
    tcnt_nxt = tmo_cnt;
    busy_nxt = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (found) begin
          idx_nxt = pick;
          vid_nxt = pick_id;
          gnt_nxt = one_pick;
          vs_nxt  = 1'b1;
        end
      end
      ISSUE: cnt_nxt = '0;
      WAIT: begin
        if (done_ok) begin
          rv_nxt  = one_idx;
          res_nxt = val_result;
        end else if (tmo_hit) begin
          rv_nxt   = one_idx;
          res_nxt  = 2'b01;
          tmo_nxt  = 1'b1;
          tcnt_nxt = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      RESP: begin
        ptr_nxt = idx;
        vid_nxt = '0;
      end
      default: ;
    endcase
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(lane_gnt));
  a_rsp_onehot : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rsp_valid));
  a_rsp_quiet  : assert property (@(posedge clk) disable iff (!reset_n)
                                  (rsp_valid == '0) |-> (rsp_result == 2'b00 && !rsp_tmo));

endmodule
